// File: rtl/fir_pkg.sv
// fir_pkg: default sizes, sequencer states and circular address arithmetic shared by the FIR tap sequencer
package fir_pkg;
    localparam int DEF_DWIDTH = 16;
    localparam int DEF_AWIDTH = 6;
    localparam int DEF_NTAPS  = 64;
    typedef enum logic [2:0] {IDLE, WRITE, RUN, DRAIN, DONE} state_e;
    function automatic int unsigned wrap_sub(int unsigned a, int unsigned b, int unsigned aw);
        return (a - b) & ((32'd1 << aw) - 32'd1);
    endfunction
endpackage

// File: rtl/fir_addr_gen.sv
// fir_addr_gen: write pointer, tap counter and newest-to-oldest circular read address generation
module fir_addr_gen
    import fir_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int NTAPS  = DEF_NTAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              adv_i,
    output logic [AWIDTH-1:0] wptr_o,
    output logic [AWIDTH-1:0] raddr_o,
    output logic [AWIDTH-1:0] tap_o,
    output logic              last_o
);
    logic [AWIDTH-1:0] wptr_q, wptr_d, tap_q, tap_d, raddr_q, raddr_d;
    always_comb begin
        wptr_d  = adv_i ? wptr_q + AWIDTH'(1) : wptr_q;
        tap_d   = (adv_i || load_i) ? '0 : (step_i ? tap_q + AWIDTH'(1) : tap_q);
        raddr_d = (load_i || step_i) ? AWIDTH'(wrap_sub(32'(wptr_q), 32'(tap_d), AWIDTH)) : raddr_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            tap_q   <= '0;
            raddr_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            tap_q   <= tap_d;
            raddr_q <= raddr_d;
        end
    end
    assign wptr_o  = wptr_q;
    assign raddr_o = raddr_q;
    assign tap_o   = tap_q;
    assign last_o  = tap_q == AWIDTH'(NTAPS - 1);
endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: writes each sample, walks all taps newest-to-oldest and drives MAC control and result strobe.
// Define FIRSEQ_DECIM_EN to add decim_m: every sample is written, a result is computed once per decim_m samples.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int NTAPS  = DEF_NTAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_stb,
    input  logic [DWIDTH-1:0] din,
`ifdef FIRSEQ_DECIM_EN
    input  logic [7:0]        decim_m,
`endif
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_waddr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic [AWIDTH-1:0] mem_raddr,
    output logic [AWIDTH-1:0] coef_raddr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              result_stb,
    output logic              busy,
    output logic              ovr_flag,
    input  logic              ovr_clr
);
    state_e            state_q;
    logic              mem_we_q, mac_clr_q, mac_en_q, result_stb_q, busy_q, ovr_q, run_ok, last;
    logic [AWIDTH-1:0] mem_waddr_q, wptr, raddr, tap;
    logic [DWIDTH-1:0] mem_wdata_q;

    if (NTAPS < 1 || NTAPS > (1 << AWIDTH)) begin : g_ntaps_chk
        $error("fir_tap_sequencer: NTAPS must be in 1..2**AWIDTH");
    end

    fir_addr_gen #(.AWIDTH(AWIDTH), .NTAPS(NTAPS)) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (state_q == WRITE && run_ok),
        .step_i  (state_q == RUN && !last),
        .adv_i   (state_q == DONE),
        .wptr_o  (wptr),
        .raddr_o (raddr),
        .tap_o   (tap),
        .last_o  (last)
    );

`ifdef FIRSEQ_DECIM_EN
    logic [7:0] dcnt_q, dcnt_d;
    assign run_ok = dcnt_q == '0;
    assign dcnt_d = (state_q != WRITE) ? dcnt_q :
                    (decim_m <= 8'd1 || dcnt_q >= decim_m - 8'd1) ? '0 : dcnt_q + 8'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dcnt_q <= '0;
        else        dcnt_q <= dcnt_d;
    end
`else
    assign run_ok = 1'b1;
`endif

    // MAC flags trail the address phase by one cycle to match the synchronous memory read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            mac_clr_q    <= 1'b0;
            mac_en_q     <= 1'b0;
            result_stb_q <= 1'b0;
            busy_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            mem_we_q     <= 1'b0;
            result_stb_q <= 1'b0;
            mac_en_q     <= state_q == RUN;
            mac_clr_q    <= state_q == RUN && tap == '0;
            ovr_q        <= (sample_stb && state_q != IDLE) || (ovr_q && !ovr_clr);
            case (state_q)
                IDLE: if (sample_stb) begin
                    state_q     <= WRITE;
                    mem_we_q    <= 1'b1;
                    mem_waddr_q <= wptr;
                    mem_wdata_q <= din;
                    busy_q      <= 1'b1;
                end
                WRITE: state_q <= run_ok ? RUN : DONE;
                RUN:   if (last) state_q <= DRAIN;
                DRAIN: begin
                    state_q      <= DONE;
                    result_stb_q <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_raddr  = raddr;
    assign coef_raddr = tap;
    assign mac_clr    = mac_clr_q;
    assign mac_en     = mac_en_q;
    assign result_stb = result_stb_q;
    assign busy       = busy_q;
    assign ovr_flag   = ovr_q;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: drives samples into the sequencer with a memory/ROM/MAC model and scores writes and sums.
module tb_fir_tap_sequencer;
    import fir_pkg::*;
    localparam int DW = DEF_DWIDTH, AW = DEF_AWIDTH, NT = DEF_NTAPS, DEPTH = 1 << AW;
    typedef struct { logic [AW-1:0] waddr; logic [DW-1:0] wdata; } wr_t;
    typedef struct { logic [63:0] sum; int c0; } res_t;
    typedef struct { logic [DW-1:0] din; logic [AW-1:0] waddr; } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, sample_stb = 1'b0, ovr_clr = 1'b0;
    logic [DW-1:0] din = '0;
    logic mem_we, mac_clr, mac_en, result_stb, busy, ovr_flag;
    logic [AW-1:0] mem_waddr, mem_raddr, coef_raddr;
    logic [DW-1:0] mem_wdata;
`ifdef FIRSEQ_DECIM_EN
    logic [7:0] decim_m = 8'd1;
    int scnt = 0;
`endif

    int checks = 0, errors = 0, cyc = 0, run_c0 = 0, nen = 0, nclr = 0, nres = 0, c0 = 0, n0 = 0;
    bit run_on = 1'b0;
    logic [AW-1:0] run_wa = '0, exp_wptr = '0;
    logic [DW-1:0] mem [DEPTH] = '{default: '0};
    logic [DW-1:0] exp_mem [DEPTH] = '{default: '0};
    logic [DW-1:0] rdata = '0, cdata = '0;
    logic [63:0] acc = '0;
    wr_t wr_q[$];
    res_t res_q[$];
    wr_t w;
    res_t r;
    vec_t vecs[8];

    fir_tap_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_stb (sample_stb),
        .din        (din),
`ifdef FIRSEQ_DECIM_EN
        .decim_m    (decim_m),
`endif
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .coef_raddr (coef_raddr),
        .mac_clr    (mac_clr),
        .mac_en     (mac_en),
        .result_stb (result_stb),
        .busy       (busy),
        .ovr_flag   (ovr_flag),
        .ovr_clr    (ovr_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] coef_of(logic [AW-1:0] k);
        return DW'(3 * int'(k) + 1);
    endfunction

    // circular memory and coefficient ROM with one-cycle read latency, plus the accumulator
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rdata <= mem[mem_raddr];
        cdata <= coef_of(coef_raddr);
        if (mac_en) acc <= mac_clr ? 64'(rdata) * 64'(cdata) : acc + 64'(rdata) * 64'(cdata);
        cyc <= cyc + 1;
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            nen = 0;
            nclr = 0;
        end else begin
            if (mem_we) begin
                if (wr_q.size() == 0) chk("stray_mem_we", 64'(mem_we), 64'(0));
                else begin
                    w = wr_q.pop_front();
                    chk("mem_waddr", 64'(mem_waddr), 64'(w.waddr));
                    chk("mem_wdata", 64'(mem_wdata), 64'(w.wdata));
                end
            end
            if (run_on && cyc - run_c0 >= 2 && cyc - run_c0 <= NT + 1) begin
                chk("mem_raddr", 64'(mem_raddr), 64'(AW'(run_wa - AW'(cyc - run_c0 - 2))));
                chk("coef_raddr", 64'(coef_raddr), 64'(cyc - run_c0 - 2));
            end
            nen += int'(mac_en);
            nclr += int'(mac_clr);
            if (result_stb) begin
                nres++;
                if (res_q.size() == 0) chk("stray_result_stb", 64'(result_stb), 64'(0));
                else begin
                    r = res_q.pop_front();
                    chk("mac_sum", acc, r.sum);
                    chk("result_latency", 64'(cyc - r.c0), 64'(NT + 3));
                    chk("mac_en_count", 64'(nen), 64'(NT));
                    chk("mac_clr_count", 64'(nclr), 64'(1));
                end
                nen = 0;
                nclr = 0;
            end
        end
    end

    task automatic go_edge();
        @(posedge clk);
        #1;
    endtask

    // expected write and (when due) expected filter sum from the bench's own view of memory
    task automatic push(logic [DW-1:0] d, logic [AW-1:0] wa);
        logic [63:0] s = '0;
        bit res = 1'b1;
`ifdef FIRSEQ_DECIM_EN
        res = scnt == 0;
        scnt = (decim_m <= 8'd1 || scnt >= int'(decim_m) - 1) ? 0 : scnt + 1;
`endif
        exp_mem[exp_wptr] = d;
        for (int k = 0; k < NT; k++) s += 64'(coef_of(AW'(k))) * 64'(exp_mem[exp_wptr - AW'(k)]);
        wr_q.push_back('{wa, d});
        if (res) res_q.push_back('{s, cyc});
        run_on = res;
        run_c0 = cyc;
        run_wa = wa;
        exp_wptr = exp_wptr + AW'(1);
    endtask

    task automatic send(logic [DW-1:0] d, bit accept, logic clr, logic [AW-1:0] wa);
        sample_stb = 1'b1;
        din = d;
        ovr_clr = clr;
        if (accept) push(d, wa);
        go_edge();
        sample_stb = 1'b0;
        ovr_clr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || res_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n >= 400), 64'(0));
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        chk({tag, "_mem_waddr"}, 64'(mem_waddr), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_mem_raddr"}, 64'(mem_raddr), 64'(0));
        chk({tag, "_coef_raddr"}, 64'(coef_raddr), 64'(0));
        chk({tag, "_mac_clr"}, 64'(mac_clr), 64'(0));
        chk({tag, "_mac_en"}, 64'(mac_en), 64'(0));
        chk({tag, "_result_stb"}, 64'(result_stb), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_ovr_flag"}, 64'(ovr_flag), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{'{16'h1234, 6'd1}, '{16'hFFFF, 6'd2}, '{16'h0000, 6'd3}, '{16'h8000, 6'd4},
                 '{16'h00FF, 6'd5}, '{16'h7FFF, 6'd6}, '{16'h0001, 6'd7}, '{16'hA5A5, 6'd8}};
        go_edge();
        chk_zero("reset");
        go_edge();
        rst_n = 1'b1;
        // first sample: write at address 0, result at cycle 67, idle at 68
        go_edge();
        c0 = cyc;
        send(16'h0005, 1'b1, 1'b0, 6'd0);
        while (cyc < c0 + NT + 3) @(negedge clk);
        chk("result_stb_at_done", 64'(result_stb), 64'(1));
        chk("busy_at_done", 64'(busy), 64'(1));
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'(0));
        for (int i = 0; i < 8; i++) begin
            go_edge();
            send(vecs[i].din, 1'b1, 1'b0, vecs[i].waddr);
            wait_idle();
        end
        for (int i = 0; i < DEPTH - 9; i++) begin
            go_edge();
            send(DW'($urandom), 1'b1, 1'b0, exp_wptr);
            wait_idle();
        end
        go_edge();
        send(16'hBEEF, 1'b1, 1'b0, 6'd0);
        wait_idle();
        // overrun in the middle of a run, then clear
        go_edge();
        send(16'h1111, 1'b1, 1'b0, exp_wptr);
        repeat (9) go_edge();
        send(16'h2222, 1'b0, 1'b0, exp_wptr);
        chk("ovr_set_midrun", 64'(ovr_flag), 64'(1));
        wait_idle();
        go_edge();
        ovr_clr = 1'b1;
        go_edge();
        ovr_clr = 1'b0;
        chk("ovr_cleared", 64'(ovr_flag), 64'(0));
        // overrun coinciding with clear: set wins
        go_edge();
        send(16'h3333, 1'b1, 1'b0, exp_wptr);
        repeat (9) go_edge();
        send(16'h4444, 1'b0, 1'b1, exp_wptr);
        chk("ovr_set_beats_clr", 64'(ovr_flag), 64'(1));
        wait_idle();
        go_edge();
        ovr_clr = 1'b1;
        go_edge();
        ovr_clr = 1'b0;
        chk("ovr_cleared_again", 64'(ovr_flag), 64'(0));
        // strobe in DONE is dropped, one cycle later is accepted
        go_edge();
        send(16'h5555, 1'b1, 1'b0, exp_wptr);
        repeat (NT + 2) go_edge();
        send(16'h6666, 1'b0, 1'b0, exp_wptr);
        chk("ovr_set_in_done", 64'(ovr_flag), 64'(1));
        send(16'h7777, 1'b1, 1'b0, exp_wptr);
        wait_idle();
        // reset in the middle of a run
        go_edge();
        send(16'h9999, 1'b1, 1'b0, exp_wptr);
        repeat (29) go_edge();
        rst_n = 1'b0;
        #1;
        chk_zero("midrun_reset");
        wr_q.delete();
        res_q.delete();
        run_on = 1'b0;
        exp_wptr = '0;
        n0 = nres;
        go_edge();
        rst_n = 1'b1;
        repeat (NT + 16) @(negedge clk);
        chk("no_result_after_reset", 64'(nres - n0), 64'(0));
        go_edge();
        send(16'hCAFE, 1'b1, 1'b0, 6'd0);
        wait_idle();
`ifdef FIRSEQ_DECIM_EN
        go_edge();
        rst_n = 1'b0;
        wr_q.delete();
        res_q.delete();
        run_on = 1'b0;
        exp_wptr = '0;
        scnt = 0;
        go_edge();
        rst_n = 1'b1;
        decim_m = 8'd4;
        n0 = nres;
        for (int i = 0; i < 8; i++) begin
            go_edge();
            send(DW'($urandom), 1'b1, 1'b0, exp_wptr);
            wait_idle();
        end
        chk("decim_result_count", 64'(nres - n0), 64'(2));
        decim_m = 8'd1;
`endif
        repeat (4) @(negedge clk);
        chk("writes_outstanding", 64'(wr_q.size()), 64'(0));
        chk("results_outstanding", 64'(res_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
